// File: rtl/score_digits_driver_if.sv
// Score digit driver bus: frame/score input, pixel coordinates, and cell
// addressing outputs to the digit bitmap stage.
interface score_digits_driver_if #(
    parameter int SCORE_W = 14
);
    logic               startOfFrame;
    logic [SCORE_W-1:0] score;
    logic [10:0]        pixelX;
    logic [10:0]        pixelY;
    logic [3:0]         digit;
    logic [10:0]        offsetX;
    logic [10:0]        offsetY;
    logic               InsideRectangle;
    logic               busy;
    logic               overflow;

    modport master (
        output startOfFrame, score, pixelX, pixelY,
        input  digit, offsetX, offsetY, InsideRectangle, busy, overflow
    );

    modport slave (
        input  startOfFrame, score, pixelX, pixelY,
        output digit, offsetX, offsetY, InsideRectangle, busy, overflow
    );
endinterface

// File: rtl/score_digits_driver.sv
// score_digits_driver: once-per-frame binary->BCD conversion (double dabble)
// and combinational mapping of the pixel into a row of digit cells.
// The displayed digits only change on COMMIT, so a frame never shows a
// half-converted score.
// Optional macro LEADING_ZERO_BLANK_EN: hide leading zero cells (the least
// significant cell is always drawn).
module score_digits_driver #(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 16,
    parameter int DIGIT_H    = 32,
    parameter int SPACING    = 2,
    parameter int TOP_LEFT_X = 16,
    parameter int TOP_LEFT_Y = 8
) (
    input logic                clk,
    input logic                resetN,
    score_digits_driver_if.slave bus
);
    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          PITCH   = DIGIT_W + SPACING;
    localparam int          CNT_W   = $clog2(SCORE_W + 1);
    localparam int          KW      = $clog2(NUM_DIGITS + 1);
    localparam int unsigned MAX_VAL = (10 ** NUM_DIGITS) - 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               ovf_q, ovf_d;

    logic sample_en, load_en, shift_en, commit_en, busy_c;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state: a startOfFrame outside IDLE is simply not looked at
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.startOfFrame) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: datapath enables and busy flag
    always_comb begin
        sample_en = 1'b0;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        commit_en = 1'b0;
        busy_c    = 1'b1;
        case (state_q)
            IDLE: begin
                busy_c    = 1'b0;
                sample_en = bus.startOfFrame;
            end
            LOAD:    load_en   = 1'b1;
            SHIFT:   shift_en  = 1'b1;
            COMMIT:  commit_en = 1'b1;
            default: busy_c    = 1'b0;
        endcase
    end

    // Conversion datapath next-state: sample, clamp+load, add-3/shift, commit
    always_comb begin
        score_d = score_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        if (sample_en)
            score_d = bus.score;
        if (load_en) begin
            // Saturate so the BCD register can never overflow its digits
            if (64'(score_q) > 64'(MAX_VAL)) begin
                bin_d = SCORE_W'(MAX_VAL);
                ovf_d = 1'b1;
            end else begin
                bin_d = score_q;
                ovf_d = 1'b0;
            end
            bcd_d = '0;
            cnt_d = CNT_W'(SCORE_W);
        end
        if (shift_en) begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q - CNT_W'(1);
        end
        if (commit_en)
            disp_d = bcd_q;
    end

    // Conversion datapath registers; reset also zeroes the displayed digits
    always_ff @(posedge clk) begin
        if (!resetN) begin
            score_q <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            score_q <= score_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = busy_c;
    assign bus.overflow = ovf_q;

    // ---------------- pixel path (no register stage) ----------------
    logic          left_ok, top_ok, in_cell;
    logic [10:0]   rel_x, rel_y, cell_base, off_x;
    logic [KW-1:0] cell_k;
    logic [3:0]    nib;
    logic          blank_sel;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;

    // A cell is blank when it and every more significant cell hold zero
    always_comb begin
        logic z;
        z     = 1'b1;
        blank = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            z        = z & (disp_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank[k] = z && (k != NUM_DIGITS - 1);
        end
    end
`endif

    // Cell lookup by compare chain against constant cell starts; bounds
    // are tested on raw coordinates so subtraction wrap cannot leak through
    always_comb begin
        left_ok   = bus.pixelX >= 11'(TOP_LEFT_X);
        top_ok    = bus.pixelY >= 11'(TOP_LEFT_Y);
        rel_x     = bus.pixelX - 11'(TOP_LEFT_X);
        rel_y     = bus.pixelY - 11'(TOP_LEFT_Y);
        cell_k    = '0;
        cell_base = '0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            if (rel_x >= 11'(k * PITCH)) begin
                cell_k    = KW'(k);
                cell_base = 11'(k * PITCH);
            end
        end
        off_x     = rel_x - cell_base;
        nib       = 4'd0;
        blank_sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (cell_k == KW'(k)) begin
                nib = disp_q[4*(NUM_DIGITS-1-k) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                blank_sel = blank[k];
`else
                blank_sel = 1'b0;
`endif
            end
        end
        in_cell = left_ok && top_ok && (cell_k < KW'(NUM_DIGITS)) &&
                  (off_x < 11'(DIGIT_W)) && (rel_y < 11'(DIGIT_H)) && !blank_sel;
    end

    // Zero everything outside a drawn cell so downstream never addresses garbage
    always_comb begin
        bus.InsideRectangle = in_cell;
        bus.digit           = in_cell ? nib   : 4'd0;
        bus.offsetX         = in_cell ? off_x : 11'd0;
        bus.offsetY         = in_cell ? rel_y : 11'd0;
    end
endmodule

// File: tb/tb_score_digits_driver.sv
// Directed bench for score_digits_driver: table-driven pixel vectors after
// each conversion, plus hand sequences for overlap and mid-conversion reset.
module tb_score_digits_driver;
`ifdef LEADING_ZERO_BLANK_EN
    localparam int LZB = 1;
`else
    localparam int LZB = 0;
`endif

    logic clk;
    logic resetN;
    score_digits_driver_if #(.SCORE_W(14)) bus ();

    score_digits_driver dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int px;
        int py;
        int ins;
        int dg;
        int ox;
        int oy;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void add(int px, int py, int ins, int dg, int ox, int oy);
        vec_t v;
        v.px = px; v.py = py; v.ins = ins; v.dg = dg; v.ox = ox; v.oy = oy;
        tbl.push_back(v);
    endfunction

    task automatic apply_tbl(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.pixelX = 11'(tbl[i].px);
            bus.pixelY = 11'(tbl[i].py);
            #1;
            chk($sformatf("%s[%0d](%0d,%0d) inside", tag, i, tbl[i].px, tbl[i].py),
                int'(bus.InsideRectangle), tbl[i].ins);
            chk($sformatf("%s[%0d] digit", tag, i), int'(bus.digit), tbl[i].dg);
            chk($sformatf("%s[%0d] offsetX", tag, i), int'(bus.offsetX), tbl[i].ox);
            chk($sformatf("%s[%0d] offsetY", tag, i), int'(bus.offsetY), tbl[i].oy);
        end
        tbl.delete();
    endtask

    // One pulse, then count cycles busy stays high (bounded)
    task automatic convert(input int s, input string tag);
        int cyc;
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        bus.score        = 14'(s);
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, cyc, 16);
    endtask

    initial begin
        int cyc;
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.score        = '0;
        bus.pixelX       = 11'd16;
        bus.pixelY       = 11'd8;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        chk("reset busy", int'(bus.busy), 0);
        chk("reset overflow", int'(bus.overflow), 0);

        add(16, 8, 1 - LZB, 0, 0, 0);
        add(70, 8, 1, 0, 0, 0);
        apply_tbl("reset");

        // ---- 1234: digit order, gaps, edges ----
        convert(1234, "s1234");
        chk("s1234 overflow", int'(bus.overflow), 0);
        add(16, 8, 1, 1, 0, 0);
        add(34, 8, 1, 2, 0, 0);
        add(52, 8, 1, 3, 0, 0);
        add(70, 8, 1, 4, 0, 0);
        add(31, 8, 1, 1, 15, 0);
        add(32, 8, 0, 0, 0, 0);
        add(33, 8, 0, 0, 0, 0);
        add(25, 20, 1, 1, 9, 12);
        add(50, 20, 0, 0, 0, 0);
        add(85, 39, 1, 4, 15, 31);
        add(86, 39, 0, 0, 0, 0);
        add(87, 39, 0, 0, 0, 0);
        add(88, 39, 0, 0, 0, 0);
        add(85, 40, 0, 0, 0, 0);
        add(15, 8, 0, 0, 0, 0);
        add(16, 7, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(2047, 2047, 0, 0, 0, 0);
        apply_tbl("s1234");

        // ---- overflow clamps to 9999 ----
        convert(12000, "s12000");
        chk("s12000 overflow", int'(bus.overflow), 1);
        add(16, 8, 1, 9, 0, 0);
        add(34, 8, 1, 9, 0, 0);
        add(52, 8, 1, 9, 0, 0);
        add(70, 8, 1, 9, 0, 0);
        apply_tbl("s12000");

        // ---- small value, leading zeros ----
        convert(5, "s5");
        chk("s5 overflow", int'(bus.overflow), 0);
        add(16, 8, 1 - LZB, 0, 0, 0);
        add(34, 8, 1 - LZB, 0, 0, 0);
        add(52, 8, 1 - LZB, 0, 0, 0);
        add(70, 8, 1, 5, 0, 0);
        add(85, 8, 1, 5, 15, 0);
        apply_tbl("s5");

        // ---- second startOfFrame mid-conversion is ignored ----
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        bus.score        = 14'd4321;
        bus.pixelX       = 11'd70;
        bus.pixelY       = 11'd8;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 5) begin
                bus.startOfFrame = 1'b1;
                bus.score        = 14'd1111;
            end else begin
                bus.startOfFrame = 1'b0;
            end
            if (cyc == 10) chk("overlap old digit held", int'(bus.digit), 5);
            @(negedge clk);
        end
        bus.startOfFrame = 1'b0;
        chk("overlap busy cycles", cyc, 16);
        repeat (5) @(negedge clk);
        chk("overlap no restart", int'(bus.busy), 0);
        add(16, 8, 1, 4, 0, 0);
        add(34, 8, 1, 3, 0, 0);
        add(52, 8, 1, 2, 0, 0);
        add(70, 8, 1, 1, 0, 0);
        apply_tbl("s4321");

        // ---- reset mid-conversion aborts and zeroes display ----
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        bus.score        = 14'd777;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort busy before reset", int'(bus.busy), 1);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort overflow", int'(bus.overflow), 0);
        add(16, 8, 1 - LZB, 0, 0, 0);
        add(70, 8, 1, 0, 0, 0);
        apply_tbl("abort");
        repeat (20) @(negedge clk);
        chk("abort busy later", int'(bus.busy), 0);
        add(52, 8, 1 - LZB, 0, 0, 0);
        add(70, 8, 1, 0, 0, 0);
        apply_tbl("abort_late");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
